// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store sequencer between the memory stage and data memory.
// Optional event counters are enabled by defining DATA_MEM_LSU_STATS_EN.
module data_mem_lsu #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqData,
    output logic              respValid,
    input  logic              respReady,
    output logic [DATA_W-1:0] respData,
    output logic              respErr,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memWriteData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] memReadData
`ifdef DATA_MEM_LSU_STATS_EN
    ,
    output logic [15:0]       statLoads,
    output logic [15:0]       statStores,
    output logic [15:0]       statErrors
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        RESP
    } state_t;

    // One extra bit so the bound compares correctly even at 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic              wr_q;
    logic              err_q;
    logic [DATA_W-1:0] mdr;
    logic              addr_bad;
    logic              accept;

    assign addr_bad = {1'b0, reqAddr} >= DEPTH;
    assign accept   = (state == IDLE) && reqValid;

    // Ready only from state; held low while reset is asserted.
    assign reqReady  = rst && (state == IDLE);
    assign respValid = (state == RESP);
    assign respData  = mdr;
    assign respErr   = err_q;

    // Next-state sequencing: errors skip straight to the response.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (reqValid) begin
                    state_nxt = addr_bad ? RESP : SETUP;
                end
            end
            SETUP:  state_nxt = ACCESS;
            ACCESS: state_nxt = HOLD;
            HOLD:   state_nxt = RESP;
            RESP: begin
                if (respReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, latched request, registered strobes and MDR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            mdr          <= '0;
            memAddress   <= '0;
            memWriteData <= '0;
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
        end else begin
            state    <= state_nxt;
            memRead  <= (state == SETUP) && !wr_q;
            memWrite <= (state == SETUP) && wr_q;
            if (accept) begin
                wr_q         <= reqWrite;
                err_q        <= addr_bad;
                memAddress   <= reqAddr;
                memWriteData <= reqData;
                if (addr_bad) begin
                    mdr <= '0;
                end
            end
            if (state == ACCESS) begin
                mdr <= wr_q ? '0 : memReadData;
            end
            if ((state == RESP) && respReady) begin
                err_q <= 1'b0;
            end
        end
    end

`ifdef DATA_MEM_LSU_STATS_EN
    // Event counters; wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            statLoads  <= '0;
            statStores <= '0;
            statErrors <= '0;
        end else begin
            if ((state == SETUP) && !wr_q) begin
                statLoads <= statLoads + 16'd1;
            end
            if ((state == SETUP) && wr_q) begin
                statStores <= statStores + 16'd1;
            end
            if (accept && addr_bad) begin
                statErrors <= statErrors + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed tests for the data memory load/store sequencer.
// Includes a behavioural 1024-word memory driven by the DUT strobes.
module tb_data_mem_lsu;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [9:0]  reqAddr;
    logic [15:0] reqData;
    logic        respValid;
    logic        respReady;
    logic [15:0] respData;
    logic        respErr;
    logic [9:0]  memAddress;
    logic [15:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [15:0] memReadData;
`ifdef DATA_MEM_LSU_STATS_EN
    logic [15:0] statLoads;
    logic [15:0] statStores;
    logic [15:0] statErrors;
`endif

    int vectors;
    int miscompares;

    logic [15:0] mem [0:1023];

    logic [15:0] rd;
    logic        er;
    int          lat;
    int          rdp;
    int          wrp;
    int          bad;
    int          scyc;
    logic [9:0]  saddr;

    data_mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqWrite     (reqWrite),
        .reqAddr      (reqAddr),
        .reqData      (reqData),
        .respValid    (respValid),
        .respReady    (respReady),
        .respData     (respData),
        .respErr      (respErr),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memReadData  (memReadData)
`ifdef DATA_MEM_LSU_STATS_EN
        ,
        .statLoads    (statLoads),
        .statStores   (statStores),
        .statErrors   (statErrors)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memReadData = mem[memAddress];

    always @(posedge clk) begin
        if (memWrite) mem[memAddress] <= memWriteData;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one request with respReady high; reports latency and strobe activity.
    task automatic do_req(input logic w, input logic [9:0] a, input logic [15:0] d);
        int n;
        logic prev;
        reqWrite  = w;
        reqAddr   = a;
        reqData   = d;
        reqValid  = 1'b1;
        respReady = 1'b1;
        n = 0;
        while (!reqReady && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (reqReady !== 1'b1) begin
            miscompares++;
            $display("FAIL req_timeout: reqReady=%b want 1", reqReady);
        end
        tick();
        reqValid = 1'b0;
        reqAddr  = ~a;
        reqData  = ~d;
        reqWrite = ~w;
        lat = -1; rdp = 0; wrp = 0; bad = 0; scyc = -1; saddr = '0;
        rd = 'x; er = 1'bx;
        prev = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (memRead && memWrite) bad++;
            if ((memRead || memWrite) && prev) bad++;
            prev = memRead || memWrite;
            if (memRead) begin rdp++; scyc = c; saddr = memAddress; end
            if (memWrite) begin wrp++; scyc = c; saddr = memAddress; end
            if (respValid) begin
                lat = c;
                rd  = respData;
                er  = respErr;
                break;
            end
            tick();
        end
        vectors++;
        if (lat < 0) begin
            miscompares++;
            $display("FAIL resp_timeout: no respValid within 20 cycles");
        end
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (reqReady !== 1'b0) begin
            miscompares++; $display("FAIL rst_reqReady: got %b want 0", reqReady);
        end
        vectors++;
        if ({respValid, respErr, memRead, memWrite} !== 4'b0) begin
            miscompares++;
            $display("FAIL rst_flags: got %b want 0000",
                     {respValid, respErr, memRead, memWrite});
        end
        vectors++;
        if ({respData, memAddress, memWriteData} !== 42'h0) begin
            miscompares++;
            $display("FAIL rst_buses: got %h/%h/%h want 0", respData, memAddress, memWriteData);
        end
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (reqReady !== 1'b1) begin
            miscompares++; $display("FAIL rst_release_ready: got %b want 1", reqReady);
        end
    endtask

    task automatic test_load;
        do_req(1'b0, 10'd505, 16'h0000);
        vectors++;
        if (rdp !== 1 || wrp !== 0 || scyc !== 2 || saddr !== 10'd505) begin
            miscompares++;
            $display("FAIL load_strobe: rd=%0d wr=%0d cyc=%0d addr=%0d want 1 0 2 505",
                     rdp, wrp, scyc, saddr);
        end
        vectors++;
        if (lat !== 4 || rd !== 16'd6 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL load_resp: lat=%0d data=%h err=%b want 4 0006 0", lat, rd, er);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++; $display("FAIL load_overlap: got %0d want 0", bad);
        end
    endtask

    task automatic test_store_load;
        do_req(1'b1, 10'd600, 16'hFFF9);
        vectors++;
        if (wrp !== 1 || rdp !== 0 || scyc !== 2 || saddr !== 10'd600) begin
            miscompares++;
            $display("FAIL store_strobe: wr=%0d rd=%0d cyc=%0d addr=%0d want 1 0 2 600",
                     wrp, rdp, scyc, saddr);
        end
        vectors++;
        if (mem[600] !== 16'hFFF9 || rd !== 16'h0 || lat !== 4) begin
            miscompares++;
            $display("FAIL store_result: mem=%h data=%h lat=%0d want fff9 0000 4",
                     mem[600], rd, lat);
        end
        do_req(1'b0, 10'd600, 16'h1234);
        vectors++;
        if (rd !== 16'hFFF9 || er !== 1'b0 || bad !== 0) begin
            miscompares++;
            $display("FAIL store_readback: data=%h err=%b bad=%0d want fff9 0 0", rd, er, bad);
        end
    endtask

    task automatic test_errors;
        do_req(1'b0, 10'd1000, 16'h0000);
        vectors++;
        if (lat !== 1 || er !== 1'b1 || rd !== 16'h0 || rdp + wrp !== 0) begin
            miscompares++;
            $display("FAIL err_load: lat=%0d err=%b data=%h strobes=%0d want 1 1 0000 0",
                     lat, er, rd, rdp + wrp);
        end
        do_req(1'b1, 10'd1023, 16'h1234);
        vectors++;
        if (lat !== 1 || er !== 1'b1 || rd !== 16'h0 || rdp + wrp !== 0) begin
            miscompares++;
            $display("FAIL err_store: lat=%0d err=%b data=%h strobes=%0d want 1 1 0000 0",
                     lat, er, rd, rdp + wrp);
        end
        vectors++;
        if (mem[1023] !== 16'hC3C3 || mem[1000] !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL err_mem: m1023=%h m1000=%h want c3c3 a5a5", mem[1023], mem[1000]);
        end
        do_req(1'b0, 10'd999, 16'h0000);
        vectors++;
        if (er !== 1'b0 || rd !== 16'h0999 || rdp !== 1) begin
            miscompares++;
            $display("FAIL edge_999: err=%b data=%h rd=%0d want 0 0999 1", er, rd, rdp);
        end
    endtask

    task automatic test_back_to_back;
        int hold_bad;
        hold_bad = 0;
        reqWrite  = 1'b0;
        reqAddr   = 10'd505;
        reqData   = 16'h0;
        respReady = 1'b0;
        reqValid  = 1'b1;
        tick();
        tick();
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            if (respValid !== 1'b1 || respData !== 16'd6 || reqReady !== 1'b0) hold_bad++;
            if (i == 2) reqAddr = 10'd600;
            tick();
        end
        vectors++;
        if (hold_bad !== 0) begin
            miscompares++; $display("FAIL stall_hold: bad cycles %0d want 0", hold_bad);
        end
        respReady = 1'b1;
        tick();
        vectors++;
        if (reqReady !== 1'b1 || respValid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: ready=%b valid=%b want 1 0", reqReady, respValid);
        end
        tick();
        vectors++;
        if (reqReady !== 1'b0) begin
            miscompares++; $display("FAIL b2b_accept: ready=%b want 0", reqReady);
        end
        reqValid = 1'b0;
        tick();
        vectors++;
        if (memRead !== 1'b1 || memAddress !== 10'd600) begin
            miscompares++;
            $display("FAIL b2b_strobe: rd=%b addr=%0d want 1 600", memRead, memAddress);
        end
        tick();
        tick();
        vectors++;
        if (respValid !== 1'b1 || respData !== 16'hFFF9) begin
            miscompares++;
            $display("FAIL b2b_resp: valid=%b data=%h want 1 fff9", respValid, respData);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        reqWrite  = 1'b1;
        reqAddr   = 10'd510;
        reqData   = 16'h5555;
        respReady = 1'b1;
        reqValid  = 1'b1;
        tick();
        reqValid = 1'b0;
        tick();
        vectors++;
        if (memWrite !== 1'b1) begin
            miscompares++; $display("FAIL mid_strobe: memWrite=%b want 1", memWrite);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (memWrite !== 1'b0 || memAddress !== 10'd0 || memWriteData !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_async: wr=%b addr=%h data=%h want 0 0 0",
                     memWrite, memAddress, memWriteData);
        end
        vectors++;
        if (respValid !== 1'b0 || reqReady !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_flags: valid=%b ready=%b want 0 0", respValid, reqReady);
        end
        #2 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (respValid !== 1'b0 || memWrite !== 1'b0) seen++;
        end
        vectors++;
        if (seen !== 0 || reqReady !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_after: stray=%0d ready=%b want 0 1", seen, reqReady);
        end
    endtask

`ifdef DATA_MEM_LSU_STATS_EN
    task automatic test_stats;
        do_req(1'b0, 10'd1, 16'h0);
        do_req(1'b1, 10'd2, 16'h22);
        do_req(1'b0, 10'd3, 16'h0);
        do_req(1'b0, 10'd1010, 16'h0);
        do_req(1'b1, 10'd4, 16'h44);
        do_req(1'b0, 10'd5, 16'h0);
        vectors++;
        if (statLoads !== 16'd3 || statStores !== 16'd2 || statErrors !== 16'd1) begin
            miscompares++;
            $display("FAIL stats_count: %0d %0d %0d want 3 2 1",
                     statLoads, statStores, statErrors);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (statLoads !== 16'd0 || statStores !== 16'd0 || statErrors !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_reset: %0d %0d %0d want 0 0 0",
                     statLoads, statStores, statErrors);
        end
        #2 rst = 1'b1;
        tick();
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        reqValid    = 1'b0;
        reqWrite    = 1'b0;
        reqAddr     = '0;
        reqData     = '0;
        respReady   = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        mem[505]  = 16'd6;
        mem[600]  = 16'h0;
        mem[999]  = 16'h0999;
        mem[1000] = 16'hA5A5;
        mem[1023] = 16'hC3C3;
        test_reset();
        test_load();
        test_store_load();
        test_errors();
        test_back_to_back();
        test_reset_mid();
`ifdef DATA_MEM_LSU_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
